// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared AES S-box tables, mode encoding and byte type
package aes_sbox_pkg;

  typedef logic [7:0] byte_t;

  localparam logic SBOX_FWD = 1'b0;
  localparam logic SBOX_INV = 1'b1;

  localparam byte_t SBOX_FWD_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - one byte lane of forward/inverse S-box lookup
module aes_sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] value,
  input  logic       mode,
  output logic [7:0] result
);

  // Pure table lookup; the mode bit picks SubBytes or InvSubBytes.
  always_comb begin
    result = SBOX_FWD_TABLE[value];
    if (mode == SBOX_INV) result = SBOX_INV_TABLE[value];
  end

endmodule

// File: rtl/aes_sub_bytes_stream.sv
// rtl/aes_sub_bytes_stream.sv - pipelined multi-lane AES SubBytes/InvSubBytes stream engine
module aes_sub_bytes_stream
  import aes_sbox_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic                 input_mode,
  input  logic [8*LANES-1:0]   input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic                 output_mode,
  output logic [8*LANES-1:0]   output_data,
  output logic                 busy
);

  localparam int WIDTH = 8 * LANES;

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_sub_bytes_stream: LANES must be within 1..16");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("aes_sub_bytes_stream: PIPE_DEPTH must be within 1..4");
  end

  logic [WIDTH-1:0]                 lookup;
  logic [PIPE_DEPTH-1:0]            stage_valid;
  logic [PIPE_DEPTH-1:0]            stage_mode;
  logic [PIPE_DEPTH-1:0]            stage_ready;
  logic [PIPE_DEPTH-1:0][WIDTH-1:0] stage_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .value  (input_data[8*i +: 8]),
      .mode   (input_mode),
      .result (lookup[8*i +: 8])
    );
  end

  // Backpressure ripples from the consumer toward the input; an empty stage always accepts.
  always_comb begin
    logic downstream;
    downstream  = output_ready;
    stage_ready = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] || downstream;
      downstream     = stage_ready[k];
    end
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic             feed_valid;
    logic             feed_mode;
    logic [WIDTH-1:0] feed_data;
    logic             valid_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;

    if (k == 0) begin : g_head
      assign feed_valid = input_valid;
      assign feed_mode  = input_mode;
      assign feed_data  = lookup;
    end else begin : g_tail
      assign feed_valid = stage_valid[k-1];
      assign feed_mode  = stage_mode[k-1];
      assign feed_data  = stage_data[k-1];
    end

    // Stage register: moves only when downstream has room, otherwise holds its beat.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        mode_q  <= SBOX_FWD;
        data_q  <= '0;
      end else if (stage_ready[k]) begin
        valid_q <= feed_valid;
        if (feed_valid) begin
          mode_q <= feed_mode;
          data_q <= feed_data;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_mode[k]  = mode_q;
    assign stage_data[k]  = data_q;
  end

  assign input_ready  = stage_ready[0] && !reset;
  assign output_valid = stage_valid[PIPE_DEPTH-1];
  assign output_mode  = stage_mode[PIPE_DEPTH-1];
  assign output_data  = stage_data[PIPE_DEPTH-1];
  assign busy         = |stage_valid;

endmodule

// File: tb/tb_aes_sub_bytes_stream.sv
// tb/tb_aes_sub_bytes_stream.sv - self-checking bench for aes_sub_bytes_stream
module tb_aes_sub_bytes_stream;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fwd_ref [256];
  logic [7:0] inv_ref [256];
  logic       sweep_en = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_mode;
  logic [31:0] out_data;
  logic        busy;

  aes_sub_bytes_stream #(.LANES(4), .PIPE_DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (in_valid),
    .input_ready  (in_ready),
    .input_mode   (in_mode),
    .input_data   (in_data),
    .output_valid (out_valid),
    .output_ready (out_ready),
    .output_mode  (out_mode),
    .output_data  (out_data),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [31:0] ref_word(input logic m, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m ? inv_ref[d[8*i +: 8]] : fwd_ref[d[8*i +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int L = (g % 2 == 1) ? 16 : 1;
    localparam int D = (g < 2) ? 1 : 4;
    logic           iv = 1'b0, im = 1'b0, ord = 1'b0, done = 1'b0;
    logic [8*L-1:0] id = '0;
    logic           ir, ov, om, bz;
    logic [8*L-1:0] od;

    aes_sub_bytes_stream #(.LANES(L), .PIPE_DEPTH(D)) dut_s (
      .clock (clock), .reset (reset),
      .input_valid (iv), .input_ready (ir), .input_mode (im), .input_data (id),
      .output_valid (ov), .output_ready (ord), .output_mode (om), .output_data (od),
      .busy (bz)
    );

    function automatic logic [8*L-1:0] expect_of(input logic m, input logic [8*L-1:0] d);
      logic [8*L-1:0] r;
      for (int i = 0; i < L; i++) r[8*i +: 8] = m ? inv_ref[d[8*i +: 8]] : fwd_ref[d[8*i +: 8]];
      return r;
    endfunction

    initial begin : run
      logic [8*L:0] q[$];
      logic [8*L:0] got, want, prev_out;
      logic         prev_stall, took;
      int           beats;
      prev_stall = 1'b0; took = 1'b0; beats = 0; prev_out = '0;
      wait (sweep_en);
      for (int c = 0; c < 1500; c++) begin
        @(negedge clock);
        if (!(iv && !took)) begin
          iv = (c < 1480) ? 1'($urandom_range(0, 1)) : 1'b0;
          im = 1'($urandom_range(0, 1));
          for (int i = 0; i < L; i++) id[8*i +: 8] = 8'($urandom);
        end
        ord = (c < 1480) ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        got = {om, od};
        if (prev_stall) begin
          checks++;
          if (!ov || got !== prev_out) begin
            failures++;
            $display("FAIL sweep%0d_hold actual=%0h required=%0h", g, got, prev_out);
          end
        end
        if (ov && ord) begin
          checks++;
          beats++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sweep%0d_spurious actual=%0h required=none", g, got);
          end else begin
            want = q.pop_front();
            if (got !== want) begin
              failures++;
              $display("FAIL sweep%0d_data actual=%0h required=%0h", g, got, want);
            end
          end
        end
        took = iv && ir;
        if (took) q.push_back({im, expect_of(im, id)});
        checks++;
        if (q.size() > D) begin
          failures++;
          $display("FAIL sweep%0d_capacity actual=%0d required<=%0d", g, q.size(), D);
        end
        prev_stall = ov && !ord;
        prev_out   = got;
      end
      check($sformatf("sweep%0d_leftover", g), q.size(), 0);
      check($sformatf("sweep%0d_enough_beats", g), beats > 100, 1);
      done = 1'b1;
    end
  end

  typedef struct {
    logic        mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  initial begin
    vec_t        vt[6];
    logic [7:0]  inv, s;
    logic [31:0] a, b, c_w, dat[16];
    logic [32:0] exp_q[16];
    int          lat, k, first, last, seen, cyc;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_ref[x] = s;
      inv_ref[s] = 8'(x);
    end

    vt[0] = '{1'b0, 32'h53020100, 32'hED777C63};
    vt[1] = '{1'b1, 32'hED777C63, 32'h53020100};
    vt[2] = '{1'b1, 32'h00000016, 32'h525252FF};
    vt[3] = '{1'b0, 32'hFFFFFFFF, 32'h16161616};
    vt[4] = '{1'b0, 32'h00000000, 32'h63636363};
    vt[5] = '{1'b1, 32'h00000000, 32'h52525252};

    #1 reset = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", in_ready, 0);
    @(negedge clock);
    check("rst_data", out_data, 0);
    check("rst_mode", out_mode, 0);
    reset = 1'b0;
    #1 check("ready_after_reset", in_ready, 1);

    foreach (vt[i]) begin
      @(negedge clock);
      out_ready = 1'b1; in_valid = 1'b1; in_mode = vt[i].mode; in_data = vt[i].din;
      @(posedge clock);
      lat = 0;
      do begin
        @(negedge clock);
        in_valid = 1'b0;
        lat++;
        #1;
      end while (!out_valid && lat < 10);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_data", i), out_data, vt[i].dout);
      check($sformatf("vec%0d_mode", i), out_mode, vt[i].mode);
      @(negedge clock);
      #1 check($sformatf("vec%0d_drained", i), {out_valid, busy}, 0);
    end

    a = $urandom; b = $urandom; c_w = $urandom;
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = a;
    @(negedge clock);
    in_mode = 1'b1; in_data = b;
    @(negedge clock);
    in_mode = 1'b0; in_data = c_w;
    #1;
    check("stall_ready_low", in_ready, 0);
    check("stall_first", {out_valid, out_mode, out_data}, {2'b10, ref_word(1'b0, a)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("stall_hold%0d", i), {in_ready, out_valid, out_mode, out_data}, {3'b010, ref_word(1'b0, a)});
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    check("stall_out_a", {out_valid, out_mode, out_data}, {2'b10, ref_word(1'b0, a)});
    @(negedge clock);
    in_valid = 1'b0;
    #1 check("stall_out_b", {out_valid, out_mode, out_data}, {2'b11, ref_word(1'b1, b)});
    @(negedge clock);
    #1 check("stall_out_c", {out_valid, out_mode, out_data}, {2'b10, ref_word(1'b0, c_w)});
    @(negedge clock);
    #1 check("stall_empty", {out_valid, busy}, 0);

    for (int i = 0; i < 16; i++) begin
      dat[i]   = $urandom;
      exp_q[i] = {1'(i % 2), ref_word(1'(i % 2), dat[i])};
    end
    k = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (c < 16) begin
        in_valid = 1'b1; in_mode = 1'(c % 2); in_data = dat[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        if (k < 16) check($sformatf("stream_beat%0d", k), {out_mode, out_data}, exp_q[k]);
        k++;
      end
      if (c == 17) check("stream_busy_last", busy, 1);
      if (c == 18) check("stream_busy_fall", busy, 0);
    end
    check("stream_first_cycle", first, 2);
    check("stream_last_cycle", last, 17);
    check("stream_count", k, 16);

    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = $urandom;
    @(negedge clock);
    in_data = $urandom;
    @(negedge clock);
    in_valid = 1'b0;
    #2 check("midrst_inflight", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_data", out_data, 0);
    in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1 check("midrst_ready_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1 if (out_valid || busy) seen++;
    end
    check("midrst_no_stale", seen, 0);

    sweep_en = 1'b1;
    cyc = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    check("sweep_completed",
          {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done, g_sweep[3].done}, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_stream.md
Name: aes_sub_bytes_stream

Overview:
Parametrised, pipelined AES byte-substitution engine with valid/ready streaming on both sides. It is the successor to the single-byte forward S-box.
- Processes LANES bytes per beat.
- Selects forward (SubBytes) or inverse (InvSubBytes) substitution per beat.
- Has a configurable register pipeline with full backpressure.
- Sits between the key-schedule/round datapath and the state registers: LANES=4 serves SubWord, LANES=16 serves a full-state SubBytes.

Parameters:
LANES, 4, bytes substituted per beat (1..16); data width = 8*LANES
PIPE_DEPTH, 2, register stages between input handshake and output (1..4); latency in cycles

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
input_valid  input  1  producer presents a beat
input_ready  output  1  engine can accept a beat this cycle
input_mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
input_data  input  8*LANES  lane i = bits [8i+7:8i]
output_valid  output  1  result beat available
output_ready  input  1  consumer accepts the result
output_mode  output  1  mode the beat was processed with
output_data  output  8*LANES  substituted bytes, lane-aligned with input
busy  output  1  OR of all stage valid bits

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All stage valid bits, data registers and mode registers clear to 0 immediately on reset assertion.
  - Outputs during and after reset: output_valid=0, output_data=0, output_mode=0, busy=0.
  - input_ready is forced to 0 while reset is high, and is 1 on the first cycle after release.
- Transfer: occurs on a rising clock edge when valid && ready are both high on that interface.
- Lookup: combinational per lane. S(x) if mode=0, InvS(x) if mode=1, applied to input_data. The result is captured into stage 0. Stages 1..PIPE_DEPTH-1 only delay data, mode and valid.
- Stage k advance rule: ready_k = !valid_k || ready_{k+1}, with ready_{PIPE_DEPTH} = output_ready. input_ready = ready_0.
  - The ready path is combinational through the stages.
  - Bubbles collapse: an empty stage always accepts.
- Latency: a beat accepted at edge n appears with output_valid=1 after edge n+PIPE_DEPTH-1, i.e. PIPE_DEPTH cycles, when unstalled.
- Throughput: one beat per cycle sustained while output_ready=1.
- Capacity: PIPE_DEPTH beats. With output_ready held low, input_ready drops after PIPE_DEPTH accepts.
- Output stability: once output_valid=1, output_data and output_mode are held stable until output_ready=1 at a clock edge.
- Simultaneous accept and drain on a full pipeline: allowed. All stages shift and occupancy is unchanged.
- Ordering: strict FIFO; modes may change beat to beat with no flush or penalty.
- Reset mid-operation: all in-flight beats are discarded with no partial output. A beat presented during reset is not accepted.
- Data registers load only on stage advance; a stalled stage holds its contents.
- Illegal parameters (LANES outside 1..16, PIPE_DEPTH outside 1..4) are rejected at elaboration.

Decomposition:
- Shared package aes_sbox_pkg:
  - 256-entry forward S-box constant array.
  - 256-entry inverse S-box constant array.
  - Mode encoding constants SBOX_FWD=0 and SBOX_INV=1.
  - Byte type.
- Sub-module aes_sbox_lane: combinational 8-bit in, mode in, 8-bit out lookup from the package tables, instantiated LANES times via generate.
- Pipeline stages are built in this block as a generate loop over PIPE_DEPTH.

Test Plan:
- LANES=4, PIPE_DEPTH=2, output_ready=1, mode=0, input_data=0x53020100 -> output_data=0xED777C63 with output_valid high exactly 2 cycles after accept, output_mode=0.
- Same configuration, mode=1, input_data=0xED777C63 -> output_data=0x53020100. Then mode=1, 0x16 in lane 0 -> 0xFF in lane 0.
- output_ready=0, three back-to-back beats A, B, C presented -> A and B accepted, input_ready=0 while C is held. output_data=S(A) stays stable for 5 stall cycles. Raise output_ready -> A, B, C emerge in order on consecutive cycles.
- Continuous 16 beats of alternating modes with output_ready=1 -> 16 results on 16 consecutive cycles, first at accept+PIPE_DEPTH, each matching the per-beat mode; busy falls the cycle after the last drain.
- Two beats in flight, assert reset asynchronously mid-cycle -> output_valid and busy go to 0 before the next edge, and no stale beat appears after release. input_ready=1 on the first post-reset cycle.
- Sweep LANES={1,16} x PIPE_DEPTH={1,4} with random valid/ready toggling against a reference model -> zero mismatches and no handshake-rule violations.
